// File: rtl/bcp_core_pkg.sv
// bcp_core_pkg: shared widths, the packed clause literal and the BCP FSM state encoding.
`default_nettype none

package bcp_core_pkg;

  localparam int MAX_VARS_BITS    = 6;
  localparam int MAX_CLAUSES_BITS = 8;
  localparam int DEF_CLAUSE_LITS  = 3;
  localparam int LIT_W            = MAX_VARS_BITS + 2;

  typedef struct packed {
    logic                     valid;
    logic                     neg;
    logic [MAX_VARS_BITS-1:0] vid;
  } lit_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_EVAL    = 3'd2,
    S_RESOLVE = 3'd3,
    S_PUSH    = 3'd4,
    S_HALT    = 3'd5
  } bcp_state_e;

endpackage

`default_nettype wire

// File: rtl/bcp_core_fifo.sv
// bcp_idx_fifo: synchronous first-word-fall-through clause-index queue with flush.
`default_nettype none

module bcp_idx_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;

  // Extra pointer MSB distinguishes full from empty.
  always_ff @(posedge clock) begin
    if (reset || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (i_push && !i_flush && !reset) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/bcp_core.sv
// bcp_core: fetches queued clauses, evaluates literals against var-state, pushes implications / flags conflicts.
// Optional macro BCP_EARLY_EXIT_EN: stop reading slots once a true literal is found.
`default_nettype none

module bcp_core
  import bcp_core_pkg::*;
#(
  parameter int FIFO_DEPTH  = 64,
  parameter int CLAUSE_LITS = DEF_CLAUSE_LITS
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             i_reset_bcp,
  input  logic                             i_bcp_en,
  input  logic [MAX_CLAUSES_BITS-1:0]      i_bcp_clause_idx,
  output logic                             o_bcp_busy,
  output logic                             o_conflict,
  output logic                             o_bcp_overflow,
  output logic                             o_clause_rd_en,
  output logic [MAX_CLAUSES_BITS-1:0]      o_clause_rd_idx,
  input  logic [CLAUSE_LITS*LIT_W-1:0]     i_clause_rd_data,
  output logic                             o_vs_rd_en,
  output logic [MAX_VARS_BITS-1:0]         o_vs_rd_var,
  input  logic                             i_vs_val,
  input  logic                             i_vs_unassign,
  input  logic                             i_full_imply,
  output logic                             o_push_imply,
  output logic [MAX_VARS_BITS-1:0]         o_var_in_imply,
  output logic                             o_val_in_imply,
  output logic                             o_type_in_imply
);

  localparam int SLOT_W = $clog2(CLAUSE_LITS) + 1;

  bcp_state_e                  r_state;
  bcp_state_e                  w_state_nxt;
  lit_t [CLAUSE_LITS-1:0]      r_clause;
  logic [SLOT_W-1:0]           r_slot;
  logic                        r_true_seen;
  logic [1:0]                  r_ucnt;
  logic [MAX_VARS_BITS-1:0]    r_cand_vid;
  logic                        r_cand_neg;
  logic                        r_conflict;
  logic                        r_overflow;

  lit_t                        w_cur;
  logic                        w_nxt_valid;
  logic [MAX_VARS_BITS-1:0]    w_nxt_vid;
  logic                        w_cur_true;
  logic                        w_cur_unassign;
  logic                        w_last;
  logic                        w_stop_early;
  logic                        w_halt;
  logic                        w_fifo_push;
  logic                        w_fifo_pop;
  logic                        w_fifo_flush;
  logic                        w_fifo_full;
  logic                        w_fifo_empty;
  logic [MAX_CLAUSES_BITS-1:0] w_fifo_dout;
  logic                        w_drop;
  logic                        w_set_conflict;
  logic                        w_clause_rd_en;
  logic                        w_push;

  assign w_halt       = (r_state == S_HALT);
  assign w_fifo_push  = i_bcp_en && !w_halt && !i_reset_bcp && !w_fifo_full;
  assign w_drop       = i_bcp_en && !w_halt && !i_reset_bcp && w_fifo_full;
  assign w_fifo_flush = i_reset_bcp || w_halt;

  bcp_idx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (MAX_CLAUSES_BITS)
  ) u_idx_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_flush (w_fifo_flush),
    .i_push  (w_fifo_push),
    .i_pop   (w_fifo_pop),
    .i_data  (i_bcp_clause_idx),
    .o_data  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Slot k is evaluated while the read for slot k+1 is issued.
  always_comb begin
    w_cur       = '0;
    w_nxt_valid = 1'b0;
    w_nxt_vid   = '0;
    for (int i = 0; i < CLAUSE_LITS; i++) begin
      if (int'(r_slot) == i) w_cur = r_clause[i];
      if (int'(r_slot) + 1 == i) begin
        w_nxt_valid = r_clause[i].valid;
        w_nxt_vid   = r_clause[i].vid;
      end
    end
  end

  assign w_last         = (int'(r_slot) == CLAUSE_LITS - 1);
  assign w_cur_true     = w_cur.valid && !i_vs_unassign && (i_vs_val == !w_cur.neg);
  assign w_cur_unassign = w_cur.valid && i_vs_unassign;

`ifdef BCP_EARLY_EXIT_EN
  assign w_stop_early = w_cur_true;
`else
  assign w_stop_early = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset || i_reset_bcp) begin
      r_state     <= S_IDLE;
      r_clause    <= '0;
      r_slot      <= '0;
      r_true_seen <= 1'b0;
      r_ucnt      <= '0;
      r_cand_vid  <= '0;
      r_cand_neg  <= 1'b0;
      r_conflict  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_drop)         r_overflow <= 1'b1;
      if (w_set_conflict) r_conflict <= 1'b1;
      case (r_state)
        S_LOAD: begin
          r_clause    <= i_clause_rd_data;
          r_slot      <= '0;
          r_true_seen <= 1'b0;
          r_ucnt      <= '0;
        end
        S_EVAL: begin
          r_slot <= r_slot + 1'b1;
          if (w_cur_unassign) begin
            if (r_ucnt != 2'd2) r_ucnt <= r_ucnt + 2'd1;
            r_cand_vid <= w_cur.vid;
            r_cand_neg <= w_cur.neg;
          end
          if (w_cur_true) r_true_seen <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fifo_pop     = 1'b0;
    w_clause_rd_en = 1'b0;
    o_vs_rd_en     = 1'b0;
    o_vs_rd_var    = '0;
    w_push         = 1'b0;
    w_set_conflict = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_fifo_pop     = 1'b1;
          w_clause_rd_en = 1'b1;
          w_state_nxt    = S_LOAD;
        end
      end
      S_LOAD: begin
        // Slot 0 comes straight from the returning clause word.
        o_vs_rd_en  = i_clause_rd_data[LIT_W-1];
        o_vs_rd_var = i_clause_rd_data[MAX_VARS_BITS-1:0];
        w_state_nxt = S_EVAL;
      end
      S_EVAL: begin
        if (w_nxt_valid && !w_stop_early) begin
          o_vs_rd_en  = 1'b1;
          o_vs_rd_var = w_nxt_vid;
        end
        if (w_last || w_stop_early) w_state_nxt = S_RESOLVE;
      end
      S_RESOLVE: begin
        if (!r_true_seen && r_ucnt == 2'd1) begin
          w_state_nxt = S_PUSH;
        end else if (!r_true_seen && r_ucnt == 2'd0) begin
          w_set_conflict = 1'b1;
          w_state_nxt    = S_HALT;
        end else if (!w_fifo_empty) begin
          w_fifo_pop     = 1'b1;
          w_clause_rd_en = 1'b1;
          w_state_nxt    = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PUSH: begin
        if (!i_full_imply) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_reset_bcp) begin
      w_state_nxt    = S_IDLE;
      w_fifo_pop     = 1'b0;
      w_clause_rd_en = 1'b0;
      o_vs_rd_en     = 1'b0;
      o_vs_rd_var    = '0;
      w_push         = 1'b0;
      w_set_conflict = 1'b0;
    end
  end

  assign o_bcp_busy      = !w_halt && (i_bcp_en || !w_fifo_empty || (r_state != S_IDLE));
  assign o_conflict      = r_conflict;
  assign o_bcp_overflow  = r_overflow;
  assign o_clause_rd_en  = w_clause_rd_en;
  assign o_clause_rd_idx = w_clause_rd_en ? w_fifo_dout : '0;
  assign o_push_imply    = w_push;
  assign o_var_in_imply  = w_push ? r_cand_vid : '0;
  assign o_val_in_imply  = w_push && !r_cand_neg;
  assign o_type_in_imply = w_push;

endmodule

`default_nettype wire

// File: tb/tb_bcp_core.sv
// tb_bcp_core: directed and randomized scoreboard bench for bcp_core.
`default_nettype none

module tb_bcp_core;
  import bcp_core_pkg::*;

  localparam int LW   = MAX_VARS_BITS + 2;
  localparam int NL   = DEF_CLAUSE_LITS;
  localparam int CW   = NL * LW;
  localparam int NVAR = 2 ** MAX_VARS_BITS;
  localparam int NCL  = 2 ** MAX_CLAUSES_BITS;

  logic                        clock;
  logic                        reset;
  logic                        i_reset_bcp;
  logic                        i_bcp_en;
  logic [MAX_CLAUSES_BITS-1:0] i_bcp_clause_idx;
  logic                        o_bcp_busy;
  logic                        o_conflict;
  logic                        o_bcp_overflow;
  logic                        o_clause_rd_en;
  logic [MAX_CLAUSES_BITS-1:0] o_clause_rd_idx;
  logic [CW-1:0]               i_clause_rd_data;
  logic                        o_vs_rd_en;
  logic [MAX_VARS_BITS-1:0]    o_vs_rd_var;
  logic                        i_vs_val;
  logic                        i_vs_unassign;
  logic                        i_full_imply;
  logic                        o_push_imply;
  logic [MAX_VARS_BITS-1:0]    o_var_in_imply;
  logic                        o_val_in_imply;
  logic                        o_type_in_imply;

  bcp_core #(.FIFO_DEPTH(64), .CLAUSE_LITS(NL)) dut (
    .clock            (clock),
    .reset            (reset),
    .i_reset_bcp      (i_reset_bcp),
    .i_bcp_en         (i_bcp_en),
    .i_bcp_clause_idx (i_bcp_clause_idx),
    .o_bcp_busy       (o_bcp_busy),
    .o_conflict       (o_conflict),
    .o_bcp_overflow   (o_bcp_overflow),
    .o_clause_rd_en   (o_clause_rd_en),
    .o_clause_rd_idx  (o_clause_rd_idx),
    .i_clause_rd_data (i_clause_rd_data),
    .o_vs_rd_en       (o_vs_rd_en),
    .o_vs_rd_var      (o_vs_rd_var),
    .i_vs_val         (i_vs_val),
    .i_vs_unassign    (i_vs_unassign),
    .i_full_imply     (i_full_imply),
    .o_push_imply     (o_push_imply),
    .o_var_in_imply   (o_var_in_imply),
    .o_val_in_imply   (o_val_in_imply),
    .o_type_in_imply  (o_type_in_imply)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { logic [MAX_VARS_BITS-1:0] v; logic val; } exp_t;

  logic [CW-1:0] db [NCL];
  logic          tb_val [NVAR];
  logic          tb_un  [NVAR];
  exp_t                        exp_push[$];
  logic [MAX_CLAUSES_BITS-1:0] exp_rd[$];
  bit  model_halt, exp_conflict, rand_full;
  int  n_checks, n_pass, n_push;

  // Clause DB and var-state memories: one-cycle read latency.
  always @(posedge clock) begin
    if (o_clause_rd_en) i_clause_rd_data <= db[o_clause_rd_idx];
    if (o_vs_rd_en) begin
      i_vs_val      <= tb_val[o_vs_rd_var];
      i_vs_unassign <= tb_un[o_vs_rd_var];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [LW-1:0] lit(input bit valid, input bit neg, input int v);
    return {valid, neg, MAX_VARS_BITS'(v)};
  endfunction

  // Reference: a clause is satisfied, unit (one unassigned, nothing true) or conflicting.
  function automatic int model_eval(input logic [CW-1:0] w, output exp_t e);
    int ucnt = 0;
    bit tru = 0;
    logic [LW-1:0] l;
    e = '{'0, 1'b0};
    for (int i = 0; i < NL; i++) begin
      l = w[i*LW +: LW];
      if (l[LW-1]) begin
        if (tb_un[l[MAX_VARS_BITS-1:0]]) begin
          ucnt++;
          e = '{l[MAX_VARS_BITS-1:0], ~l[LW-2]};
        end else if (tb_val[l[MAX_VARS_BITS-1:0]] == ~l[LW-2]) begin
          tru = 1;
        end
      end
    end
    if (tru) return 0;
    if (ucnt == 1) return 1;
    if (ucnt == 0) return 2;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    if (rand_full) i_full_imply = ($urandom_range(0, 3) == 0);
  endtask

  task automatic issue(input int idx);
    exp_t e;
    int   k;
    i_bcp_en = 1'b1;
    i_bcp_clause_idx = MAX_CLAUSES_BITS'(idx);
    if (!model_halt) begin
      exp_rd.push_back(MAX_CLAUSES_BITS'(idx));
      k = model_eval(db[idx], e);
      if (k == 1) exp_push.push_back(e);
      else if (k == 2) begin
        model_halt   = 1;
        exp_conflict = 1;
      end
    end
    tick();
    i_bcp_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int cyc);
    cyc = 0;
    while (o_bcp_busy && cyc < 3000) begin
      tick();
      cyc++;
    end
    check({name, "_idle_timeout"}, o_bcp_busy, 0);
  endtask

  task automatic do_reset_bcp();
    i_reset_bcp = 1'b1;
    exp_push.delete();
    exp_rd.delete();
    model_halt   = 0;
    exp_conflict = 0;
    tick();
    i_reset_bcp = 1'b0;
  endtask

  // Monitor: every push and every clause read is matched against the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      if (o_push_imply) begin
        n_push++;
        check("push_while_full", i_full_imply, 0);
        check("push_type", o_type_in_imply, 1);
        if (exp_push.size() == 0) begin
          check("push_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_push.pop_front();
          check("push_var", o_var_in_imply, e.v);
          check("push_val", o_val_in_imply, e.val);
        end
      end
      if (o_clause_rd_en) begin
        if (exp_rd.size() == 0) check("read_unexpected", 1, 0);
        else check("read_idx", o_clause_rd_idx, exp_rd.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, np;
    logic [CW-1:0] w;
    n_checks = 0; n_pass = 0; n_push = 0;
    model_halt = 0; exp_conflict = 0; rand_full = 0;
    reset = 1'b1; i_reset_bcp = 1'b0; i_bcp_en = 1'b0; i_bcp_clause_idx = '0;
    i_full_imply = 1'b0; i_clause_rd_data = '0; i_vs_val = 1'b0; i_vs_unassign = 1'b0;
    for (int i = 0; i < NCL; i++) db[i] = '0;
    for (int i = 0; i < NVAR; i++) begin tb_val[i] = 1'b0; tb_un[i] = 1'b1; end

    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("rst_busy", o_bcp_busy, 0);
    check("rst_conflict", o_conflict, 0);
    check("rst_overflow", o_bcp_overflow, 0);
    check("rst_push", o_push_imply, 0);
    check("rst_clause_rd", o_clause_rd_en, 0);
    check("rst_vs_rd", o_vs_rd_en, 0);

    // (x1 | ~x2 | x3), x1=0, x2=1, x3 unassigned: unit on x3=1
    db[1] = {lit(1, 0, 3), lit(1, 1, 2), lit(1, 0, 1)};
    tb_un[1] = 0; tb_val[1] = 0;
    tb_un[2] = 0; tb_val[2] = 1;
    np = n_push;
    issue(1);
    check("t1_rd_en_next", o_clause_rd_en, 1);
    check("t1_rd_idx", o_clause_rd_idx, 1);
    wait_idle("t1", cyc);
    check("t1_idle_cycles", cyc, 7);
    check("t1_push_count", n_push - np, 1);

    // x3=0: conflict, busy drops the cycle after RESOLVE
    tb_un[3] = 0; tb_val[3] = 0;
    issue(1);
    wait_idle("t2", cyc);
    check("t2_idle_cycles", cyc, 6);
    check("t2_conflict", o_conflict, 1);
    i_bcp_en = 1'b1; i_bcp_clause_idx = 8'd1;
    #1;
    check("t2_busy_halt_en", o_bcp_busy, 0);
    tick();
    i_bcp_en = 1'b0;
    repeat (4) tick();
    check("t2_conflict_sticky", o_conflict, 1);
    do_reset_bcp();
    check("t2_conflict_cleared", o_conflict, 0);
    check("t2_busy_after_clear", o_bcp_busy, 0);

    // (x20 | x21 | x22), x20=1: satisfied, no push
    db[5] = {lit(1, 0, 22), lit(1, 0, 21), lit(1, 0, 20)};
    tb_un[20] = 0; tb_val[20] = 1;
    np = n_push;
    issue(5);
    wait_idle("t3", cyc);
`ifdef BCP_EARLY_EXIT_EN
    check("t3_idle_cycles", cyc, 4);
`else
    check("t3_idle_cycles", cyc, 6);
`endif
    check("t3_no_push", n_push - np, 0);

    // Three back-to-back indices
    db[2] = {lit(0, 0, 0), lit(0, 0, 0), lit(1, 0, 10)};
    db[3] = {lit(0, 0, 0), lit(1, 0, 1), lit(1, 1, 11)};
    db[4] = {lit(1, 1, 2), lit(0, 0, 5), lit(1, 1, 12)};
    np = n_push;
    issue(2); issue(3); issue(4);
    wait_idle("t4", cyc);
    check("t4_push_count", n_push - np, 3);
    check("t4_push_drained", exp_push.size(), 0);
    check("t4_reads_drained", exp_rd.size(), 0);

    // Unit clause held in PUSH by full_imply for 4 cycles
    db[6] = {lit(0, 0, 0), lit(0, 1, 9), lit(1, 0, 30)};
    i_full_imply = 1'b1;
    np = n_push;
    issue(6);
    repeat (10) tick();
    check("t5_no_push_while_full", n_push - np, 0);
    i_full_imply = 1'b0;
    #1;
    check("t5_push_on_drop", o_push_imply, 1);
    tick();
    check("t5_push_once", n_push - np, 1);
    check("t5_push_deasserted", o_push_imply, 0);
    wait_idle("t5", cyc);

    // Overflow, then reset_bcp while the clause waits in PUSH
    i_full_imply = 1'b1;
    for (int i = 0; i < 70; i++) issue(6);
    check("t6_overflow", o_bcp_overflow, 1);
    check("t6_busy", o_bcp_busy, 1);
    i_full_imply = 1'b0;
    i_reset_bcp = 1'b1;
    exp_push.delete(); exp_rd.delete();
    #1;
    check("t6_no_push_on_reset_bcp", o_push_imply, 0);
    tick();
    i_reset_bcp = 1'b0;
    #1;
    check("t6_idle_after", o_bcp_busy, 0);
    check("t6_overflow_cleared", o_bcp_overflow, 0);
    repeat (5) tick();
    check("t6_still_idle", o_bcp_busy, 0);

    // Randomized rounds against the reference model
    rand_full = 1;
    for (int r = 0; r < 40; r++) begin
      for (int c = 16; c < 32; c++) begin
        for (int s = 0; s < NL; s++)
          w[s*LW +: LW] = lit($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                              32 + $urandom_range(0, 7));
        db[c] = w;
      end
      for (int v = 32; v < 40; v++) begin
        tb_un[v]  = ($urandom_range(0, 1) == 1);
        tb_val[v] = ($urandom_range(0, 1) == 1);
      end
      for (int b = 0, nb = $urandom_range(1, 5); b < nb; b++) begin
        issue($urandom_range(16, 31));
        repeat ($urandom_range(0, 3)) tick();
      end
      wait_idle("rnd", cyc);
      check("rnd_push_drained", exp_push.size(), 0);
      check("rnd_reads_drained", exp_rd.size(), 0);
      check("rnd_conflict", o_conflict, exp_conflict);
      check("rnd_overflow", o_bcp_overflow, 0);
      if (exp_conflict) do_reset_bcp();
    end
    rand_full = 0;
    i_full_imply = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
